hazard_stall_ctrl: RTL and testbench

//  Hazard detection and stall/flush controller; the stall-side counterpart of the EX-stage forwarding unit.

---
 rtl/hazard_stall_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall/flush controller for a 5-stage pipeline.
// It handles the hazards that bypassing cannot cover: load-use, data-memory
// wait states and taken branches. It drives the pipeline-register write
// enables, the bubble/flush controls and two saturating performance counters.
// Outputs are Mealy, so a hazard takes effect in the same cycle it is seen.
module hazard_stall_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_uses_rs1,
    input  logic             if_id_uses_rs2,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             ex_mem_hold,
    output logic             stall_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Reload values for the 2-bit down-counter (cycles remaining after the first).
    localparam logic [1:0]       LU_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [1:0]       FL_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic load_use;
    logic mem_stall;
    logic rs1_match;
    logic rs2_match;

    // Internal (pre-reset-gating) control values.
    logic pc_write_c;
    logic if_id_write_c;
    logic id_ex_write_c;
    logic id_ex_bubble_c;
    logic if_id_flush_c;
    logic ex_mem_hold_c;
    logic flush_inc;

    // Hazard terms: x0 is never a real dependency, and an operand only counts if it is read.
    always_comb begin
        rs1_match = if_id_uses_rs1 && (if_id_rs1 == id_ex_rd);
        rs2_match = if_id_uses_rs2 && (if_id_rs2 == id_ex_rd);
        load_use  = id_ex_memread && (id_ex_rd != 5'd0) && (rs1_match || rs2_match);
        mem_stall = dmem_req && !dmem_ready;
    end

    // Next-state and Mealy control: memory freeze overrides everything, then branch, then load-use.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        id_ex_write_c  = 1'b1;
        id_ex_bubble_c = 1'b0;
        if_id_flush_c  = 1'b0;
        ex_mem_hold_c  = 1'b0;
        flush_inc      = 1'b0;

        if (mem_stall) begin
            // Whole pipeline frozen; state and cnt hold so the sequence resumes intact.
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_write_c = 1'b0;
            ex_mem_hold_c = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ex_branch_taken) begin
                        // Redirect: PC takes the target, wrong-path IF/ID and ID/EX are squashed.
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        flush_inc      = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = FL_RELOAD;
                        end
                    end else if (load_use) begin
                        pc_write_c     = 1'b0;
                        if_id_write_c  = 1'b0;
                        id_ex_bubble_c = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = LU_RELOAD;
                        end
                    end
                end

                LU_STALL: begin
                    if (ex_branch_taken) begin
                        // The stalled instruction is on the wrong path; drop the stall and redirect.
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        flush_inc      = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = FL_RELOAD;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = 2'd0;
                        end
                    end else begin
                        pc_write_c     = 1'b0;
                        if_id_write_c  = 1'b0;
                        id_ex_bubble_c = 1'b1;
                        cnt_d          = cnt_q - 2'd1;
                        if (cnt_q <= 2'd1) begin
                            state_d = IDLE;
                        end
                    end
                end

                FLUSH: begin
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    if (ex_branch_taken) begin
                        // A new redirect restarts the flush window.
                        cnt_d     = FL_RELOAD;
                        flush_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                        if (cnt_q <= 2'd1) begin
                            state_d = IDLE;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // Saturating performance counters; a stalled PC includes freeze cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!pc_write_c && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (flush_inc && (flush_events_q != CNT_MAX)) begin
            flush_events_d = flush_events_q + 1'b1;
        end
    end

    // State, down-counter and performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 2'd0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // While reset is asserted the pipeline runs freely regardless of hazard inputs.
    always_comb begin
        if (!rst_n) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
            ex_mem_hold  = 1'b0;
            stall_busy   = 1'b0;
        end else begin
            pc_write     = pc_write_c;
            if_id_write  = if_id_write_c;
            id_ex_write  = id_ex_write_c;
            id_ex_bubble = id_ex_bubble_c;
            if_id_flush  = if_id_flush_c;
            ex_mem_hold  = ex_mem_hold_c;
            stall_busy   = (state_q != IDLE);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Two instances share the inputs:
// u_a (1 load bubble, 2 flush cycles, 32-bit counters) and
// u_b (2 load bubbles, 3 flush cycles, 3-bit counters to reach saturation).
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
    logic       if_id_uses_rs1, if_id_uses_rs2, id_ex_memread;
    logic       ex_branch_taken, dmem_req, dmem_ready;

    logic        a_pc, a_ifid, a_idex, a_bub, a_fl, a_hold, a_busy;
    logic [31:0] a_stall, a_flush;
    logic        b_pc, b_ifid, b_idex, b_bub, b_fl, b_hold, b_busy;
    logic [2:0]  b_stall, b_flush;

    logic [6:0] va, vb;
    assign va = {a_pc, a_ifid, a_idex, a_bub, a_fl, a_hold, a_busy};
    assign vb = {b_pc, b_ifid, b_idex, b_bub, b_fl, b_hold, b_busy};

    // Output vector {pc_write, if_id_write, id_ex_write, bubble, flush, hold, busy}
    localparam logic [6:0] O_IDLE  = 7'b1110000;
    localparam logic [6:0] O_LU0   = 7'b0011000;
    localparam logic [6:0] O_LU    = 7'b0011001;
    localparam logic [6:0] O_BR0   = 7'b1111100;
    localparam logic [6:0] O_FL    = 7'b1111101;
    localparam logic [6:0] O_FRZ0  = 7'b0000010;
    localparam logic [6:0] O_FRZ   = 7'b0000011;

    int checks = 0;
    int failures = 0;

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(a_pc), .if_id_write(a_ifid), .id_ex_write(a_idex),
        .id_ex_bubble(a_bub), .if_id_flush(a_fl), .ex_mem_hold(a_hold),
        .stall_busy(a_busy), .stall_cycles(a_stall), .flush_events(a_flush)
    );

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(b_pc), .if_id_write(b_ifid), .id_ex_write(b_idex),
        .id_ex_bubble(b_bub), .if_id_flush(b_fl), .ex_mem_hold(b_hold),
        .stall_busy(b_busy), .stall_cycles(b_stall), .flush_events(b_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_ex_rd = 5'd0;
        if_id_uses_rs1 = 1'b0; if_id_uses_rs2 = 1'b0; id_ex_memread = 1'b0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // lw x5 in EX, ID instruction "add x7, x1, x5" (x5 read through rs2)
    task automatic load_use_inputs();
        idle_inputs();
        id_ex_memread = 1'b1; id_ex_rd = 5'd5;
        if_id_rs1 = 5'd1; if_id_uses_rs1 = 1'b1;
        if_id_rs2 = 5'd5; if_id_uses_rs2 = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive a step at the falling edge; the caller checks #1 later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        load_use_inputs();
        ex_branch_taken = 1'b1;
        dmem_req = 1'b1;
        // Reset: outputs forced idle even with every hazard input active
        @(negedge clk); #1;
        chk("rst_out_a", 32'(va), 32'(O_IDLE));
        chk("rst_out_b", 32'(vb), 32'(O_IDLE));
        chk("rst_stall_a", a_stall, 32'd0);
        chk("rst_flush_b", 32'(b_flush), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Load-use with one bubble
        step(); load_use_inputs(); #1;
        chk("lu1_c1_a", 32'(va), 32'(O_LU0));
        chk("lu1_c1_b", 32'(vb), 32'(O_LU0));
        step(); idle_inputs(); #1;
        chk("lu1_c2_a", 32'(va), 32'(O_IDLE));
        chk("lu1_stall_a", a_stall, 32'd1);

        // x0 destination and a non-reading ID instruction never stall
        do_reset();
        step();
        idle_inputs(); id_ex_memread = 1'b1; id_ex_rd = 5'd0;
        if_id_uses_rs1 = 1'b1; if_id_uses_rs2 = 1'b1; #1;
        chk("x0_a", 32'(va), 32'(O_IDLE));
        chk("x0_b", 32'(vb), 32'(O_IDLE));
        step();
        idle_inputs(); id_ex_memread = 1'b1; id_ex_rd = 5'd5;
        if_id_rs1 = 5'd5; if_id_rs2 = 5'd5; #1;
        chk("lui_a", 32'(va), 32'(O_IDLE));
        chk("lui_b", 32'(vb), 32'(O_IDLE));
        step(); idle_inputs(); #1;
        chk("nostall_cnt_a", a_stall, 32'd0);

        // Load-use with two bubbles
        do_reset();
        step(); load_use_inputs(); #1;
        chk("lu2_c1_b", 32'(vb), 32'(O_LU0));
        step(); idle_inputs(); #1;
        chk("lu2_c2_b", 32'(vb), 32'(O_LU));
        step(); #1;
        chk("lu2_c3_b", 32'(vb), 32'(O_IDLE));
        chk("lu2_stall_b", 32'(b_stall), 32'd2);

        // Branch flush: 2 cycles on u_a, 3 on u_b
        do_reset();
        step(); ex_branch_taken = 1'b1; #1;
        chk("br_c1_a", 32'(va), 32'(O_BR0));
        chk("br_c1_b", 32'(vb), 32'(O_BR0));
        step(); ex_branch_taken = 1'b0; #1;
        chk("br_c2_a", 32'(va), 32'(O_FL));
        chk("br_c2_b", 32'(vb), 32'(O_FL));
        step(); #1;
        chk("br_c3_a", 32'(va), 32'(O_IDLE));
        chk("br_fe_a", a_flush, 32'd1);
        chk("br_c3_b", 32'(vb), 32'(O_FL));
        step(); #1;
        chk("br_c4_b", 32'(vb), 32'(O_IDLE));
        chk("br_fe_b", 32'(b_flush), 32'd1);

        // Branch beats load-use; a second branch in FLUSH restarts the window
        do_reset();
        step(); load_use_inputs(); ex_branch_taken = 1'b1; #1;
        chk("brpri_b", 32'(vb), 32'(O_BR0));
        step(); idle_inputs(); #1;
        chk("rst_c2_b", 32'(vb), 32'(O_FL));
        step(); ex_branch_taken = 1'b1; #1;
        chk("rst_c3_b", 32'(vb), 32'(O_FL));
        step(); ex_branch_taken = 1'b0; #1;
        chk("rst_fe_b", 32'(b_flush), 32'd2);
        step(); #1;
        chk("rst_c5_b", 32'(vb), 32'(O_FL));
        step(); #1;
        chk("rst_c6_b", 32'(vb), 32'(O_IDLE));
        chk("rst_stall_b", 32'(b_stall), 32'd0);

        // Branch during LU_STALL abandons the stall
        do_reset();
        step(); load_use_inputs(); #1;
        chk("abn_c1_b", 32'(vb), 32'(O_LU0));
        step(); idle_inputs(); ex_branch_taken = 1'b1; #1;
        chk("abn_c2_b", 32'(vb), 32'(O_BR0 | 7'b0000001));
        step(); ex_branch_taken = 1'b0; #1;
        chk("abn_c3_b", 32'(vb), 32'(O_FL));
        chk("abn_fe_b", 32'(b_flush), 32'd1);
        chk("abn_stall_b", 32'(b_stall), 32'd1);

        // Memory freeze for 3 cycles inside LU_STALL, then saturation of a 3-bit counter
        do_reset();
        step(); load_use_inputs(); #1;
        chk("frz_c1_b", 32'(vb), 32'(O_LU0));
        step(); idle_inputs(); dmem_req = 1'b1; #1;
        chk("frz_c2_b", 32'(vb), 32'(O_FRZ));
        chk("frz_c2_a", 32'(va), 32'(O_FRZ0));
        step(); #1;
        chk("frz_c3_b", 32'(vb), 32'(O_FRZ));
        step(); #1;
        chk("frz_c4_b", 32'(vb), 32'(O_FRZ));
        step(); dmem_ready = 1'b1; #1;
        chk("frz_rdy_b", 32'(vb), 32'(O_LU));
        step(); idle_inputs(); #1;
        chk("frz_end_b", 32'(vb), 32'(O_IDLE));
        chk("frz_stall_b", 32'(b_stall), 32'd5);
        chk("frz_stall_a", a_stall, 32'd4);
        step(); load_use_inputs(); #1;
        step(); idle_inputs(); #1;
        chk("sat_lu_b", 32'(vb), 32'(O_LU));
        step(); dmem_req = 1'b1; #1;
        chk("sat_frz_b", 32'(vb), 32'(O_FRZ0));
        step(); idle_inputs(); #1;
        chk("sat_stall_b", 32'(b_stall), 32'd7);
        chk("sat_out_b", 32'(vb), 32'(O_IDLE));

        // Asynchronous reset in the middle of FLUSH
        do_reset();
        step(); ex_branch_taken = 1'b1; #1;
        step(); ex_branch_taken = 1'b0; #1;
        chk("arst_pre_a", 32'(va), 32'(O_FL));
        chk("arst_pre_fe_a", a_flush, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_a", 32'(va), 32'(O_IDLE));
        chk("arst_fe_a", a_flush, 32'd0);
        chk("arst_fe_b", 32'(b_flush), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; #1;
        chk("arst_rel_a", 32'(va), 32'(O_IDLE));
        step(); #1;
        chk("arst_idle_a", 32'(va), 32'(O_IDLE));
        chk("arst_idle_fe_a", a_flush, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
